// File: rtl/rv32i_decode_unit.sv
// RV32I decode stage: 32x32 register file, immediate generator and all control
// signals for the ALU, data memory, write-back mux and PC mux.
module rv32i_decode_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] reg_write_data,
  input  logic        zero,
  output logic [3:0]  ALU_control,
  output logic [31:0] ExtImmediate,
  output logic [31:0] operand_b,
  output logic [31:0] rdout1,
  output logic [31:0] rdout2,
  output logic [1:0]  writeback_sel,
  output logic [1:0]  PC_sel,
  output logic [1:0]  datamemory_mode,
  output logic        datamemWE,
  output logic        reg1sel_flag
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        funct7_alt;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [3:0]  alu_base;
  logic        reg_write;
  logic        use_imm;
  logic [31:0] regs [0:31];

  assign opcode     = Instruction[6:0];
  assign rd         = Instruction[11:7];
  assign funct3     = Instruction[14:12];
  assign rs1        = Instruction[19:15];
  assign rs2        = Instruction[24:20];
  assign funct7_alt = Instruction[30];

  assign imm_i = {{20{Instruction[31]}}, Instruction[31:20]};
  assign imm_s = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
  assign imm_b = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                  Instruction[30:25], Instruction[11:8], 1'b0};
  assign imm_u = {Instruction[31:12], 12'b0};
  assign imm_j = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                  Instruction[20], Instruction[30:21], 1'b0};

  // Shared funct3 -> ALU op mapping for R-type and I-ALU; SUB/SRA patched below
  always_comb begin
    alu_base = ALU_ADD;
    case (funct3)
      3'b000: alu_base = ALU_ADD;
      3'b001: alu_base = ALU_SLL;
      3'b010: alu_base = ALU_SLT;
      3'b011: alu_base = ALU_SLTU;
      3'b100: alu_base = ALU_XOR;
      3'b101: alu_base = ALU_SRL;
      3'b110: alu_base = ALU_OR;
      3'b111: alu_base = ALU_AND;
      default: alu_base = ALU_ADD;
    endcase
  end

  always_comb begin
    ALU_control     = ALU_ADD;
    ExtImmediate    = '0;
    writeback_sel   = 2'b00;
    PC_sel          = 2'b00;
    datamemory_mode = 2'b10;
    datamemWE       = 1'b0;
    reg1sel_flag    = 1'b0;
    reg_write       = 1'b0;
    use_imm         = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write   = 1'b1;
        ALU_control = alu_base;
        if (funct7_alt && funct3 == 3'b000) ALU_control = ALU_SUB;
        if (funct7_alt && funct3 == 3'b101) ALU_control = ALU_SRA;
      end
      OP_I_ALU: begin
        reg_write    = 1'b1;
        use_imm      = 1'b1;
        ExtImmediate = imm_i;
        ALU_control  = alu_base;
        if (funct7_alt && funct3 == 3'b101) ALU_control = ALU_SRA;
      end
      OP_LOAD: begin
        reg_write       = 1'b1;
        use_imm         = 1'b1;
        ExtImmediate    = imm_i;
        writeback_sel   = 2'b01;
        datamemory_mode = funct3[1:0];
      end
      OP_STORE: begin
        use_imm         = 1'b1;
        ExtImmediate    = imm_s;
        datamemWE       = 1'b1;
        datamemory_mode = funct3[1:0];
      end
      OP_BRANCH: begin
        ExtImmediate = imm_b;
        // Reserved branch funct3 (010/011) falls back to ADD and never branches
        case (funct3)
          3'b000: begin ALU_control = ALU_SUB;  PC_sel = zero  ? 2'b01 : 2'b00; end
          3'b001: begin ALU_control = ALU_SUB;  PC_sel = !zero ? 2'b01 : 2'b00; end
          3'b100: begin ALU_control = ALU_SLT;  PC_sel = !zero ? 2'b01 : 2'b00; end
          3'b101: begin ALU_control = ALU_SLT;  PC_sel = zero  ? 2'b01 : 2'b00; end
          3'b110: begin ALU_control = ALU_SLTU; PC_sel = !zero ? 2'b01 : 2'b00; end
          3'b111: begin ALU_control = ALU_SLTU; PC_sel = zero  ? 2'b01 : 2'b00; end
          default: begin ALU_control = ALU_ADD; PC_sel = 2'b00; end
        endcase
      end
      OP_JAL: begin
        reg_write     = 1'b1;
        ExtImmediate  = imm_j;
        writeback_sel = 2'b10;
        PC_sel        = 2'b01;
        reg1sel_flag  = 1'b1;
      end
      OP_JALR: begin
        reg_write     = 1'b1;
        use_imm       = 1'b1;
        ExtImmediate  = imm_i;
        writeback_sel = 2'b10;
        PC_sel        = 2'b10;
      end
      OP_LUI: begin
        reg_write    = 1'b1;
        use_imm      = 1'b1;
        ExtImmediate = imm_u;
        ALU_control  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        reg_write    = 1'b1;
        use_imm      = 1'b1;
        ExtImmediate = imm_u;
        reg1sel_flag = 1'b1;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  // Entry 0 is only ever cleared, so x0 stays hard-wired to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_write && rd != 5'd0) begin
      regs[rd] <= reg_write_data;
    end
  end

  assign rdout1    = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rdout2    = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign operand_b = use_imm ? ExtImmediate : rdout2;

endmodule

// File: tb/tb_rv32i_decode_unit.sv
// Testbench for rv32i_decode_unit: directed steps followed by random instructions
// checked against a field-level reference model and a shadow register file.
module tb_rv32i_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic [31:0] reg_write_data;
  logic        zero;
  logic [3:0]  ALU_control;
  logic [31:0] ExtImmediate;
  logic [31:0] operand_b;
  logic [31:0] rdout1;
  logic [31:0] rdout2;
  logic [1:0]  writeback_sel;
  logic [1:0]  PC_sel;
  logic [1:0]  datamemory_mode;
  logic        datamemWE;
  logic        reg1sel_flag;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [32];

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [1:0]  wb;
    logic [1:0]  pc;
    logic [1:0]  mode;
    logic        we;
    logic        r1sel;
    logic        use_imm;
    logic        reg_write;
  } exp_t;

  always #5 clk = ~clk;

  rv32i_decode_unit dut (
    .clk             (clk),
    .reset           (reset),
    .Instruction     (Instruction),
    .reg_write_data  (reg_write_data),
    .zero            (zero),
    .ALU_control     (ALU_control),
    .ExtImmediate    (ExtImmediate),
    .operand_b       (operand_b),
    .rdout1          (rdout1),
    .rdout2          (rdout2),
    .writeback_sel   (writeback_sel),
    .PC_sel          (PC_sel),
    .datamemory_mode (datamemory_mode),
    .datamemWE       (datamemWE),
    .reg1sel_flag    (reg1sel_flag)
  );

  // Reference decode built from instruction classes and arithmetic on raw bits
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic z);
    exp_t e;
    logic [31:0] sgn;
    logic [3:0]  alu_tab [8];
    int          f3;
    logic        alt;
    bit          taken;
    alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    f3  = int'((ins >> 12) & 32'h7);
    alt = ins[30];
    e = '0;
    e.mode = 2'b10;
    case (ins & 32'h7F)
      32'h33: begin
        e.reg_write = 1;
        e.alu = alu_tab[f3];
        if (alt && f3 == 0) e.alu = 4'd1;
        if (alt && f3 == 5) e.alu = 4'd7;
      end
      32'h13: begin
        e.reg_write = 1; e.use_imm = 1;
        e.imm = (sgn << 12) | (ins >> 20);
        e.alu = alu_tab[f3];
        if (alt && f3 == 5) e.alu = 4'd7;
      end
      32'h03: begin
        e.reg_write = 1; e.use_imm = 1; e.wb = 2'b01;
        e.imm = (sgn << 12) | (ins >> 20);
        e.mode = 2'(f3 % 4);
      end
      32'h23: begin
        e.use_imm = 1; e.we = 1;
        e.imm = (sgn << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
        e.mode = 2'(f3 % 4);
      end
      32'h63: begin
        e.imm = (sgn << 12) | (((ins >> 7) & 1) << 11) |
                (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
        if (f3 == 2 || f3 == 3) begin
          e.alu = 4'd0;
          taken = 0;
        end else begin
          e.alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
          taken = (f3 == 0 || f3 == 5 || f3 == 7) ? z : !z;
        end
        e.pc = taken ? 2'b01 : 2'b00;
      end
      32'h6F: begin
        e.reg_write = 1; e.wb = 2'b10; e.pc = 2'b01; e.r1sel = 1;
        e.imm = (sgn << 20) | (((ins >> 12) & 32'hFF) << 12) |
                (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      end
      32'h67: begin
        e.reg_write = 1; e.use_imm = 1; e.wb = 2'b10; e.pc = 2'b10;
        e.imm = (sgn << 12) | (ins >> 20);
      end
      32'h37: begin
        e.reg_write = 1; e.use_imm = 1; e.alu = 4'd10;
        e.imm = ins & 32'hFFFF_F000;
      end
      32'h17: begin
        e.reg_write = 1; e.use_imm = 1; e.r1sel = 1;
        e.imm = ins & 32'hFFFF_F000;
      end
      default: e.mode = 2'b10;
    endcase
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] wd, input logic z);
    Instruction    = ins;
    reg_write_data = wd;
    zero           = z;
    #1;
  endtask

  task automatic check_output(input string tag);
    exp_t        e;
    logic [31:0] r1;
    logic [31:0] r2;
    e  = ref_decode(Instruction, zero);
    r1 = model_regs[Instruction[19:15]];
    r2 = model_regs[Instruction[24:20]];
    check_eq({tag, ".alu"},   32'(ALU_control),     32'(e.alu));
    check_eq({tag, ".imm"},   ExtImmediate,         e.imm);
    check_eq({tag, ".opb"},   operand_b,            e.use_imm ? e.imm : r2);
    check_eq({tag, ".rd1"},   rdout1,               r1);
    check_eq({tag, ".rd2"},   rdout2,               r2);
    check_eq({tag, ".wb"},    32'(writeback_sel),   32'(e.wb));
    check_eq({tag, ".pc"},    32'(PC_sel),          32'(e.pc));
    check_eq({tag, ".mode"},  32'(datamemory_mode), 32'(e.mode));
    check_eq({tag, ".we"},    32'(datamemWE),       32'(e.we));
    check_eq({tag, ".r1sel"}, 32'(reg1sel_flag),    32'(e.r1sel));
  endtask

  task automatic clock_edge();
    exp_t        e;
    logic [4:0]  rd;
    e  = ref_decode(Instruction, zero);
    rd = Instruction[11:7];
    @(posedge clk);
    if (reset && e.reg_write && rd != 5'd0) model_regs[rd] = reg_write_data;
    #2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
  endtask

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] ins;
    logic [6:0]  opc;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    reset = 1'b0;
    clear_model();
    apply_stimulus(32'h0, 32'h0, 1'b0);
    check_eq("reset.rd1", rdout1, 32'h0);
    check_eq("reset.rd2", rdout2, 32'h0);
    check_eq("reset.we", 32'(datamemWE), 32'h0);
    check_eq("reset.pc", 32'(PC_sel), 32'h0);
    check_output("reset");

    apply_stimulus(32'h00A0_0093, 32'hDEAD_BEEF, 1'b0);
    clock_edge();
    apply_stimulus(32'h0000_8113, 32'h0, 1'b0);
    check_eq("reset_blocks_write", rdout1, 32'h0);

    reset = 1'b1;
    apply_stimulus(32'h5531_2023, 32'hCAFE_F00D, 1'b0);
    check_eq("sw.imm", ExtImmediate, 32'h0000_0540);
    check_eq("sw.opb", operand_b, 32'h0000_0540);
    check_eq("sw.alu", 32'(ALU_control), 32'd0);
    check_eq("sw.we", 32'(datamemWE), 32'd1);
    check_eq("sw.mode", 32'(datamemory_mode), 32'd2);
    check_output("sw");
    clock_edge();
    check_eq("sw.no_write_rd1", rdout1, 32'h0);
    check_eq("sw.no_write_rd2", rdout2, 32'h0);

    apply_stimulus(32'h00A0_0093, 32'hDEAD_BEEF, 1'b0);
    check_eq("addi.imm", ExtImmediate, 32'hA);
    check_eq("addi.opb", operand_b, 32'hA);
    check_output("addi");
    clock_edge();
    apply_stimulus(32'h0000_8113, 32'h0, 1'b0);
    check_eq("addi.readback", rdout1, 32'hDEAD_BEEF);
    apply_stimulus(32'h0010_8093, 32'h0000_0005, 1'b0);
    check_eq("no_bypass", rdout1, 32'hDEAD_BEEF);
    clock_edge();
    check_eq("after_edge", rdout1, 32'h0000_0005);

    apply_stimulus(32'h0000_0013, 32'h1234_5678, 1'b0);
    clock_edge();
    apply_stimulus(32'h0000_0033, 32'h0, 1'b0);
    check_eq("x0.rd1", rdout1, 32'h0);
    check_eq("x0.rd2", rdout2, 32'h0);

    apply_stimulus(32'h0000_0863, 32'h0, 1'b1);
    check_eq("beq_taken.pc", 32'(PC_sel), 32'd1);
    check_eq("beq_taken.alu", 32'(ALU_control), 32'd1);
    check_output("beq_taken");
    apply_stimulus(32'h0000_0863, 32'h0, 1'b0);
    check_eq("beq_not.pc", 32'(PC_sel), 32'd0);
    apply_stimulus(32'h0000_4863, 32'h0, 1'b0);
    check_eq("blt.pc", 32'(PC_sel), 32'd1);
    check_eq("blt.alu", 32'(ALU_control), 32'd3);
    apply_stimulus(32'h0000_7863, 32'h0, 1'b1);
    check_eq("bgeu.pc", 32'(PC_sel), 32'd1);
    check_eq("bgeu.alu", 32'(ALU_control), 32'd4);

    apply_stimulus(32'h0080_00EF, 32'h0, 1'b0);
    check_eq("jal.pc", 32'(PC_sel), 32'd1);
    check_eq("jal.wb", 32'(writeback_sel), 32'd2);
    check_eq("jal.r1sel", 32'(reg1sel_flag), 32'd1);
    check_eq("jal.imm", ExtImmediate, 32'h8);
    apply_stimulus(32'h0000_80E7, 32'h0, 1'b0);
    check_eq("jalr.pc", 32'(PC_sel), 32'd2);
    apply_stimulus(32'h1234_5037, 32'h0, 1'b0);
    check_eq("lui.imm", ExtImmediate, 32'h1234_5000);
    check_eq("lui.alu", 32'(ALU_control), 32'd10);
    apply_stimulus(32'h1234_5017, 32'h0, 1'b0);
    check_eq("auipc.r1sel", 32'(reg1sel_flag), 32'd1);
    check_output("auipc");

    apply_stimulus(32'hFFFF_FFFF, 32'h5555_AAAA, 1'b1);
    check_eq("illegal.imm", ExtImmediate, 32'h0);
    check_eq("illegal.alu", 32'(ALU_control), 32'd0);
    check_output("illegal");
    clock_edge();
    apply_stimulus(32'h000F_8033, 32'h0, 1'b0);
    check_eq("illegal.no_write", rdout1, 32'h0);

    for (int n = 0; n < 400; n++) begin
      opc = (($urandom_range(0, 9) == 0)) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      ins = ($urandom & 32'hFFFF_FF80) | 32'(opc);
      apply_stimulus(ins, $urandom, 1'($urandom_range(0, 1)));
      check_output("rand");
      if ($urandom_range(0, 3) != 0) clock_edge();
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b0;
        clear_model();
        apply_stimulus(ins | 32'h01FF_8000, 32'h0, 1'b0);
        check_eq("rand_reset.rd1", rdout1, 32'h0);
        check_eq("rand_reset.rd2", rdout2, 32'h0);
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
